// File: rtl/video_timing_gen_pkg.sv
// Shared video timing definitions: 640x480@60 constants, coordinate width,
// controller state encoding and the per-axis decode bundle.
package video_timing_gen_pkg;

  localparam int COORD_W   = 12;
  localparam int COORD_MAX = (1 << COORD_W) - 1;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vtg_state_e;

  // One axis worth of counter state and decode, produced by sync_counter.
  typedef struct packed {
    coord_t cnt;
    logic   wrap;
    logic   active;
    logic   active_nxt;
    logic   sync;
  } axis_t;

  function automatic coord_t to_coord(input int v);
    return coord_t'(v);
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_counter.sv
// One timing axis: wrapping position counter plus active-region and sync decode.
// active_nxt looks at the value the counter will hold after this edge.
module sync_counter
  import video_timing_gen_pkg::*;
#(
  parameter int   ACTIVE = VGA_H_ACTIVE,
  parameter int   FP     = VGA_H_FP,
  parameter int   SYNC   = VGA_H_SYNC,
  parameter int   BP     = VGA_H_BP,
  parameter logic POL    = 1'b0
) (
  input  logic  gclk,
  input  logic  grst_n,
  input  logic  clr,
  input  logic  inc,
  output axis_t ax
);

  localparam int     TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam coord_t LAST     = to_coord(TOTAL - 1);
  localparam coord_t ACT_END  = to_coord(ACTIVE);
  localparam coord_t SYNC_BEG = to_coord(ACTIVE + FP);
  localparam coord_t SYNC_END = to_coord(ACTIVE + FP + SYNC);

  coord_t cnt;
  coord_t cnt_nxt;
  logic   wrap;
  logic   in_sync;

  assign wrap    = (cnt == LAST);
  assign in_sync = (cnt >= SYNC_BEG) && (cnt < SYNC_END);

  always_comb begin
    cnt_nxt = cnt;
    if (clr)      cnt_nxt = '0;
    else if (inc) cnt_nxt = wrap ? '0 : cnt + coord_t'(1);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) cnt <= '0;
    else         cnt <= cnt_nxt;
  end

  assign ax = '{
    cnt:        cnt,
    wrap:       wrap,
    active:     (cnt < ACT_END),
    active_nxt: (cnt_nxt < ACT_END),
    sync:       (in_sync ? POL : ~POL)
  };

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: two sync_counter axes, IDLE/RUN/DRAIN run control,
// registered video outputs, one-cycle-early pixel request and underflow flag.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE  = VGA_H_ACTIVE,
  parameter int   H_FP      = VGA_H_FP,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BP      = VGA_H_BP,
  parameter int   V_ACTIVE  = VGA_V_ACTIVE,
  parameter int   V_FP      = VGA_V_FP,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BP      = VGA_V_BP,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic               pxlclk,
  input  logic               rstn,
  input  logic               en,
  input  logic               pix_valid,
  input  logic               clr_underflow,
  output logic               hsync,
  output logic               vsync,
  output logic               dena,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               pix_req,
  output logic               frame_start,
  output logic               busy,
  output logic               underflow
);

  vtg_state_e state;
  axis_t      h_ax;
  axis_t      v_ax;
  logic       run;
  logic       last;
  logic       next_run;
  logic       act;

  assign run  = (state != ST_IDLE);
  assign last = h_ax.wrap && v_ax.wrap;
  assign act  = run && h_ax.active && v_ax.active;
  // Whether the counters will be live after this edge; the only way out of
  // RUN/DRAIN is finishing the last cycle of a frame with en low.
  assign next_run = run ? !(last && !en) : en;
  assign busy = run;

  sync_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL)
  ) u_h (
    .gclk   (pxlclk),
    .grst_n (rstn),
    .clr    (!run),
    .inc    (run),
    .ax     (h_ax)
  );

  sync_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL)
  ) u_v (
    .gclk   (pxlclk),
    .grst_n (rstn),
    .clr    (!run),
    .inc    (run && h_ax.wrap),
    .ax     (v_ax)
  );

  always_ff @(posedge pxlclk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (en) state <= ST_RUN;
        ST_RUN:   if (!en) state <= last ? ST_IDLE : ST_DRAIN;
        ST_DRAIN: begin
          if (en)        state <= ST_RUN;
          else if (last) state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pxlclk or negedge rstn) begin
    if (!rstn) begin
      dena        <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      pix_req     <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      dena        <= act;
      hsync       <= run ? h_ax.sync : ~HSYNC_POL;
      vsync       <= run ? v_ax.sync : ~VSYNC_POL;
      x           <= act ? h_ax.cnt : '0;
      y           <= act ? v_ax.cnt : '0;
      frame_start <= run && (h_ax.cnt == '0) && (v_ax.cnt == '0);
      pix_req     <= next_run && h_ax.active_nxt && v_ax.active_nxt;
      // Set has priority over clear.
      underflow   <= (dena && !pix_valid) || (underflow && !clr_underflow);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a tiny 7x5 raster: frame-position model checked
// every cycle, plus hand-computed expectations for start, drain, underflow, reset.
module tb_video_timing_gen;

  localparam int   HA = 4, HF = 1, HS = 1, HB = 1;
  localparam int   VA = 2, VF = 1, VS = 1, VB = 1;
  localparam logic HPOL = 1'b0, VPOL = 1'b0;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FT = HT * VT;

  logic        pxlclk = 1'b0;
  logic        rstn = 1'b1;
  logic        en = 1'b0;
  logic        pix_valid = 1'b1;
  logic        clr_underflow = 1'b0;
  logic        hsync, vsync, dena, pix_req, frame_start, busy, underflow;
  logic [11:0] x, y;

  int   checks = 0;
  int   errors = 0;
  logic chk_on = 1'b0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
  ) dut (
    .pxlclk(pxlclk), .rstn(rstn), .en(en), .pix_valid(pix_valid),
    .clr_underflow(clr_underflow), .hsync(hsync), .vsync(vsync), .dena(dena),
    .x(x), .y(y), .pix_req(pix_req), .frame_start(frame_start), .busy(busy),
    .underflow(underflow)
  );

  always #5 pxlclk = ~pxlclk;

  // Model: frame position p (-1 when stopped), h = p % HT, v = p / HT.
  function automatic logic f_act(input int p);
    return (p >= 0) && ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic logic f_hs(input int p);
    int h;
    if (p < 0) return ~HPOL;
    h = p % HT;
    return (h >= HA + HF && h < HA + HF + HS) ? HPOL : ~HPOL;
  endfunction

  function automatic logic f_vs(input int p);
    int v;
    if (p < 0) return ~VPOL;
    v = p / HT;
    return (v >= VA + VF && v < VA + VF + VS) ? VPOL : ~VPOL;
  endfunction

  function automatic int f_next(input int p, input logic e);
    if (p < 0) return e ? 0 : -1;
    if (p == FT - 1 && !e) return -1;
    return (p + 1) % FT;
  endfunction

  int          mpos;
  logic        e_dena, e_hs, e_vs, e_fs, e_pr, e_busy, e_uf;
  logic [11:0] e_x, e_y;

  always @(posedge pxlclk or negedge rstn) begin
    if (!rstn) begin
      mpos <= -1;
      e_dena <= 1'b0; e_hs <= ~HPOL; e_vs <= ~VPOL; e_x <= '0; e_y <= '0;
      e_fs <= 1'b0; e_pr <= 1'b0; e_busy <= 1'b0; e_uf <= 1'b0;
    end else begin
      e_dena <= f_act(mpos);
      e_hs   <= f_hs(mpos);
      e_vs   <= f_vs(mpos);
      e_x    <= f_act(mpos) ? 12'(mpos % HT) : 12'd0;
      e_y    <= f_act(mpos) ? 12'(mpos / HT) : 12'd0;
      e_fs   <= (mpos == 0);
      e_pr   <= f_act(f_next(mpos, en));
      e_busy <= (f_next(mpos, en) >= 0);
      e_uf   <= (e_dena && !pix_valid) || (e_uf && !clr_underflow);
      mpos   <= f_next(mpos, en);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pxlclk) begin
    if (chk_on) begin
      chk("dena", 32'(dena), 32'(e_dena));
      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("x", 32'(x), 32'(e_x));
      chk("y", 32'(y), 32'(e_y));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("pix_req", 32'(pix_req), 32'(e_pr));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("underflow", 32'(underflow), 32'(e_uf));
    end
  end

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for model condition", name);
  endtask

  task automatic wait_dena(input string name);
    int n = 0;
    while (e_dena !== 1'b1 && n < 100) begin @(negedge pxlclk); n++; end
    if (n >= 100) timeout(name);
  endtask

  task automatic wait_pos(input int p, input string name);
    int n = 0;
    while (mpos != p && n < 100) begin @(negedge pxlclk); n++; end
    if (n >= 100) timeout(name);
  endtask

  initial begin
    int fs_n = 0, first_fs = -1, last_fs = -1, fs_gap = 0;
    int dcnt = 0, hlo = 0, vlo = 0, xmax = 0, ymax = 0, k = 0, dc = 0;

    #1 rstn = 1'b0;
    #1 chk_on = 1'b1;
    repeat (3) @(negedge pxlclk);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_dena", 32'(dena), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_xy", 32'({x, y}), 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge pxlclk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pix_req", 32'(pix_req), 32'd0);

    // Three full frames with en held.
    en = 1'b1;
    for (int i = 0; i < 3 * FT; i++) begin
      @(negedge pxlclk);
      if (i == 0) begin
        chk("start_pix_req", 32'(pix_req), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_dena", 32'(dena), 32'd0);
      end
      if (frame_start) begin
        if (first_fs < 0) first_fs = i; else fs_gap = i - last_fs;
        last_fs = i;
        fs_n++;
      end
      if (dena) begin
        dcnt++;
        if (int'(x) > xmax) xmax = int'(x);
        if (int'(y) > ymax) ymax = int'(y);
      end
      if (!hsync) hlo++;
      if (!vsync) vlo++;
    end
    chk("first_fs", 32'(first_fs), 32'd1);
    chk("fs_gap", 32'(fs_gap), 32'd35);
    chk("fs_count", 32'(fs_n), 32'd3);
    chk("dena_count", 32'(dcnt), 32'd24);
    chk("hsync_low", 32'(hlo), 32'd15);
    chk("vsync_low", 32'(vlo), 32'd21);
    chk("x_max", 32'(xmax), 32'd3);
    chk("y_max", 32'(ymax), 32'd1);

    // en dropped exactly on the last cycle of the frame: straight to idle.
    en = 1'b0;
    @(negedge pxlclk);
    chk("last_stop_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge pxlclk);

    // Brief en drop mid-frame, then resume without disturbing counters.
    en = 1'b1;
    repeat (6) @(negedge pxlclk);
    en = 1'b0;
    repeat (3) @(negedge pxlclk);
    chk("drain_busy", 32'(busy), 32'd1);
    en = 1'b1;
    repeat (2 * FT) @(negedge pxlclk);

    // Underflow: set, sticky, clear, set-wins, ignored outside dena.
    wait_dena("uf_wait1");
    pix_valid = 1'b0;
    @(negedge pxlclk);
    pix_valid = 1'b1;
    chk("uf_set", 32'(underflow), 32'd1);
    repeat (3) @(negedge pxlclk);
    chk("uf_sticky", 32'(underflow), 32'd1);
    clr_underflow = 1'b1;
    @(negedge pxlclk);
    clr_underflow = 1'b0;
    chk("uf_clr", 32'(underflow), 32'd0);
    wait_dena("uf_wait2");
    pix_valid = 1'b0;
    clr_underflow = 1'b1;
    @(negedge pxlclk);
    pix_valid = 1'b1;
    clr_underflow = 1'b0;
    chk("uf_set_wins", 32'(underflow), 32'd1);
    clr_underflow = 1'b1;
    @(negedge pxlclk);
    clr_underflow = 1'b0;
    for (int i = 0; i < 2 * FT; i++) begin
      pix_valid = e_dena;
      @(negedge pxlclk);
    end
    pix_valid = 1'b1;
    chk("uf_ignored", 32'(underflow), 32'd0);

    // Mid-frame reset at h=2, v=1 with en held high.
    wait_pos(HT + 2, "rst_wait");
    chk("pre_rst_dena", 32'(dena), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_dena", 32'(dena), 32'd0);
    chk("mid_rst_sync", 32'({hsync, vsync}), 32'd3);
    chk("mid_rst_xy", 32'({x, y}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge pxlclk);
    rstn = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge pxlclk);
      if (j == 0) chk("post_rst_pix_req", 32'(pix_req), 32'd1);
      if (j == 1) chk("post_rst_fs", 32'(frame_start), 32'd1);
    end

    // en dropped at h=2, v=1: the frame drains to its end, then idle.
    en = 1'b0;
    do begin
      @(negedge pxlclk);
      k++;
      if (dena) dc++;
    end while (busy && k < 100);
    chk("drain_cycles", 32'(k), 32'd26);
    chk("drain_dena", 32'(dc), 32'd2);
    @(negedge pxlclk);
    chk("end_idle_sync", 32'({hsync, vsync}), 32'd3);
    chk("end_idle_dena", 32'(dena), 32'd0);
    repeat (3) @(negedge pxlclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
